flash_responder: RTL and testbench

FLASH_RESPONDER -- requirements
Module: flash_responder

---
 rtl/flash_responder.sv | 191 +++++++++++++++++++
 tb/tb_flash_responder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_responder.sv
// rtl/flash_responder.sv - fixed-latency flash read responder in front of a synchronous ROM
//
// Purpose: accepts single-word flash reads after a programmable stall and
// fetches in-range words from a backing synchronous ROM. Each response
// returns exactly READ_LATENCY cycles after its acceptance cycle, in order.
//
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   flsh_read          - read request
//   flsh_address       - 23-bit word address (sampled only on acceptance)
//   flsh_byteenable    - byte lanes to return (sampled only on acceptance)
//   flsh_waitrequest   - command stall
//   flsh_readdata      - response word, zero whenever flsh_readdatavalid is low
//   flsh_readdatavalid - one-cycle response strobe
//   mem_address        - ROM word address
//   mem_read           - ROM read strobe
//   mem_readdata       - ROM data, valid the cycle after mem_read
//   reads_served       - saturating count of responses delivered
//   range_errors       - saturating count of out-of-range commands accepted

`timescale 1ns/1ps

module flash_responder #(
    parameter int WAIT_STATES  = 2,
    parameter int READ_LATENCY = 3,
    parameter int MAX_PENDING  = 4,
    parameter int MEM_AW       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flsh_read,
    input  logic [22:0]       flsh_address,
    input  logic [3:0]        flsh_byteenable,
    output logic              flsh_waitrequest,
    output logic [31:0]       flsh_readdata,
    output logic              flsh_readdatavalid,
    output logic [MEM_AW-1:0] mem_address,
    output logic              mem_read,
    input  logic [31:0]       mem_readdata,
    output logic [15:0]       reads_served,
    output logic [7:0]        range_errors
);

    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int OUT_W = $clog2(MAX_PENDING + 1);

    typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

    state_t                state;
    logic [CNT_W-1:0]      wait_cnt;
    logic [OUT_W-1:0]      outstanding;
    logic                  accept;
    logic                  in_range;

    // vld[k] marks the command accepted k cycles ago
    logic [READ_LATENCY:1] vld;
    logic [3:0]            s1_be;
    logic                  s1_in_range;
    logic [3:0]            s2_be;
    logic                  s2_in_range;
    logic [31:0]           s2_word;
    logic [31:0]           resp_word;

    // Stall depends only on registered state so the initiator never sees a
    // combinational loop through flsh_read.
    assign flsh_waitrequest = (state != READY) || (outstanding == OUT_W'(MAX_PENDING));
    assign accept           = (state == READY) && flsh_read && !flsh_waitrequest;
    assign in_range         = (flsh_address >> MEM_AW) == 23'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flsh_read) begin
                        if (WAIT_STATES == 0) begin
                            state <= READY;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= CNT_W'(WAIT_STATES);
                        end
                    end
                end
                WAIT: begin
                    if (!flsh_read) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == CNT_W'(1)) begin
                        state    <= READY;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                READY: begin
                    // Returning to IDLE after every acceptance guarantees the
                    // minimum stall for the next command.
                    if (!flsh_read || accept) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Stage 1 (acceptance + 1): ROM access. Stage 2: ROM data arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld         <= '0;
            mem_read    <= 1'b0;
            mem_address <= '0;
            s1_be       <= '0;
            s1_in_range <= 1'b0;
            s2_be       <= '0;
            s2_in_range <= 1'b0;
        end else begin
            vld      <= {vld[READ_LATENCY-1:1], accept};
            mem_read <= accept && in_range;
            if (accept) begin
                mem_address <= flsh_address[MEM_AW-1:0];
                s1_be       <= flsh_byteenable;
                s1_in_range <= in_range;
            end
            s2_be       <= s1_be;
            s2_in_range <= s1_in_range;
        end
    end

    // Response word is formed as soon as the ROM data is present, then delayed.
    always_comb begin
        s2_word = s2_in_range ? mem_readdata : 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            if (!s2_be[i]) begin
                s2_word[8*i +: 8] = 8'h00;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_direct
            assign resp_word = s2_word;
        end else begin : g_delay
            logic [31:0] word_pipe [READ_LATENCY-2];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < READ_LATENCY - 2; i++) begin
                        word_pipe[i] <= '0;
                    end
                end else begin
                    word_pipe[0] <= s2_word;
                    for (int i = 1; i < READ_LATENCY - 2; i++) begin
                        word_pipe[i] <= word_pipe[i-1];
                    end
                end
            end

            assign resp_word = word_pipe[READ_LATENCY-3];
        end
    endgenerate

    assign flsh_readdatavalid = vld[READ_LATENCY];
    assign flsh_readdata      = vld[READ_LATENCY] ? resp_word : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding  <= '0;
            reads_served <= '0;
            range_errors <= '0;
        end else begin
            case ({accept, flsh_readdatavalid})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
            if (flsh_readdatavalid && reads_served != 16'hFFFF) begin
                reads_served <= reads_served + 16'd1;
            end
            if (accept && !in_range && range_errors != 8'hFF) begin
                range_errors <= range_errors + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_flash_responder.sv
// tb/tb_flash_responder.sv - scoreboard bench for flash_responder

`timescale 1ns/1ps

module tb_flash_responder;

    localparam int WS  = 2;
    localparam int RL  = 3;
    localparam int RL2 = 8;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst;
    int          cyc;
    int          total;
    int          bad;

    logic        rd1, wr1, rdv1, mem_read1;
    logic [22:0] addr1;
    logic [3:0]  be1;
    logic [31:0] rd_data1, mem_rdata1;
    logic [15:0] mem_addr1, served1;
    logic [7:0]  rerr1;

    logic        rd2, wr2, rdv2, mem_read2;
    logic [22:0] addr2;
    logic [3:0]  be2;
    logic [31:0] rd_data2, mem_rdata2;
    logic [15:0] mem_addr2, served2;
    logic [7:0]  rerr2;

    exp_t        q1[$];
    exp_t        q2[$];
    exp_t        e1, e2;
    int          mr_count1;
    int          valid_count1;
    int          occ2;
    int          max_occ2;

    flash_responder dut (
        .clk(clk), .rst(rst),
        .flsh_read(rd1), .flsh_address(addr1), .flsh_byteenable(be1),
        .flsh_waitrequest(wr1), .flsh_readdata(rd_data1), .flsh_readdatavalid(rdv1),
        .mem_address(mem_addr1), .mem_read(mem_read1), .mem_readdata(mem_rdata1),
        .reads_served(served1), .range_errors(rerr1)
    );

    flash_responder #(.MAX_PENDING(1), .READ_LATENCY(RL2)) dut2 (
        .clk(clk), .rst(rst),
        .flsh_read(rd2), .flsh_address(addr2), .flsh_byteenable(be2),
        .flsh_waitrequest(wr2), .flsh_readdata(rd_data2), .flsh_readdatavalid(rdv2),
        .mem_address(mem_addr2), .mem_read(mem_read2), .mem_readdata(mem_rdata2),
        .reads_served(served2), .range_errors(rerr2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rom_word(input logic [15:0] a);
        case (a)
            16'h0010: return 32'h12345678;
            16'h0011: return 32'hAABBCCDD;
            default:  return {16'h5A5A, a};
        endcase
    endfunction

    always @(posedge clk) begin
        mem_rdata1 <= mem_read1 ? rom_word(mem_addr1) : 32'h0BAD0BAD;
        mem_rdata2 <= mem_read2 ? rom_word(mem_addr2) : 32'h0BAD0BAD;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_read1) mr_count1++;
            if (rdv1) begin
                valid_count1++;
                if (q1.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid1: got data %h expected no response", rd_data1);
                end else begin
                    e1 = q1.pop_front();
                    check("readdata1", rd_data1, e1.data);
                    check("latency1", cyc, e1.due);
                end
            end else begin
                check("idle_readdata1", rd_data1, 32'h0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            occ2 = 0;
        end else begin
            occ2 = occ2 + ((rd2 && !wr2) ? 1 : 0) - (rdv2 ? 1 : 0);
            if (occ2 > max_occ2) max_occ2 = occ2;
            if (rdv2) begin
                if (q2.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid2: got data %h expected no response", rd_data2);
                end else begin
                    e2 = q2.pop_front();
                    check("readdata2", rd_data2, e2.data);
                    check("latency2", cyc, e2.due);
                end
            end else begin
                check("idle_readdata2", rd_data2, 32'h0);
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_waitrequest", wr1, 1);
        check("rst_readdatavalid", rdv1, 0);
        check("rst_readdata", rd_data1, 0);
        check("rst_mem_read", mem_read1, 0);
        check("rst_mem_address", mem_addr1, 0);
        check("rst_reads_served", served1, 0);
        check("rst_range_errors", rerr1, 0);
    endtask

    // Address/byteenable are garbage until the acceptance cycle is seen.
    task automatic do_read(input logic [22:0] a, input logic [3:0] be,
                           input logic [31:0] exp, input logic exp_mem);
        int stalls;
        bit done;
        stalls = 0;
        done   = 0;
        @(posedge clk); #1;
        rd1 = 1'b1; addr1 = ~a; be1 = ~be;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (wr1) begin
                stalls++;
            end else begin
                addr1 = a;
                be1   = be;
                q1.push_back('{exp, cyc + RL});
                done = 1;
            end
        end
        check("accept_seen", done, 1);
        check("stall_cycles", stalls, WS + 1);
        @(posedge clk); #1;
        rd1 = 1'b0; addr1 = ~a; be1 = ~be;
        @(negedge clk);
        check("mem_read_pulse", mem_read1, exp_mem);
        if (exp_mem) check("mem_address", mem_addr1, a[15:0]);
    endtask

    task automatic drain1();
        for (int i = 0; i < 40 && q1.size() != 0; i++) @(negedge clk);
        check("drain1", q1.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  m, v, n;
        bit  ok;
        int  acc2 [2];
        total = 0; bad = 0; mr_count1 = 0; valid_count1 = 0; max_occ2 = 0; occ2 = 0;
        rst = 1'b1;
        rd1 = 1'b0; addr1 = '0; be1 = '0;
        rd2 = 1'b0; addr2 = '0; be2 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        check("rst_waitrequest2", wr2, 1);

        do_read(23'h000010, 4'hF, 32'h12345678, 1'b1);
        drain1();
        check("served_after_1", served1, 1);

        do_read(23'h000011, 4'b0101, 32'h00BB00DD, 1'b1);
        drain1();
        check("served_after_2", served1, 2);

        m = mr_count1;
        do_read(23'h010000, 4'hF, 32'hDEADBEEF, 1'b0);
        drain1();
        check("range_errors_1", rerr1, 1);
        check("no_mem_read_oor", mr_count1 - m, 0);

        do_read(23'h7F0022, 4'b0011, 32'h0000BEEF, 1'b0);
        drain1();
        check("range_errors_2", rerr1, 2);

        m = mr_count1;
        v = valid_count1;
        @(posedge clk); #1;
        rd1 = 1'b1; addr1 = 23'h000010; be1 = 4'hF;
        @(posedge clk); #1;
        rd1 = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_no_mem_read", mr_count1 - m, 0);
        check("abort_no_valid", valid_count1 - v, 0);
        check("abort_waitrequest", wr1, 1);

        do_read(23'h000123, 4'b1000, 32'h5A000000, 1'b1);
        drain1();
        check("served_after_5", served1, 5);

        ok = 0;
        @(posedge clk); #1;
        rd1 = 1'b1; addr1 = 23'h000020; be1 = 4'hF;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (!wr1) ok = 1;
        end
        check("rst_test_accept", ok, 1);
        @(posedge clk); #1;
        rd1 = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        v = valid_count1;
        repeat (12) @(negedge clk);
        check("no_valid_after_reset", valid_count1 - v, 0);

        do_read(23'h000010, 4'b1100, 32'h12340000, 1'b1);
        drain1();
        check("served_after_reset", served1, 1);
        check("rerr_after_reset", rerr1, 0);

        n = 0;
        acc2[0] = 0; acc2[1] = 0;
        @(posedge clk); #1;
        rd2 = 1'b1; addr2 = 23'h000010; be2 = 4'hF;
        for (int i = 0; i < 100 && n < 2; i++) begin
            @(negedge clk);
            if (!wr2) begin
                acc2[n] = cyc;
                q2.push_back('{(n == 0) ? 32'h12345678 : 32'hAABBCCDD, cyc + RL2});
                n++;
                @(posedge clk); #1;
                addr2 = 23'h000011;
                if (n == 2) rd2 = 1'b0;
            end
        end
        check("b2b_accepts", n, 2);
        check("b2b_second_accept_cycle", acc2[1] - acc2[0], RL2 + 1);
        for (int i = 0; i < 60 && q2.size() != 0; i++) @(negedge clk);
        check("drain2", q2.size(), 0);
        @(negedge clk);
        check("max_outstanding2", max_occ2, 1);
        check("served2", served2, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
